buffer_scheduler: RTL and testbench
===================================

BUFFER_SCHEDULER -- requirements
Module: buffer_scheduler

Interface
REQ-001 SHALL have parameter BUFFER_SIZE, default 16, meaning buffer capacity in sets.
REQ-002 SHALL have parameter IN_NUM_OF_SET, default 4, meaning sets written per buffer write.
REQ-003 SHALL have parameter OUT_NUM_OF_SET, default 3, meaning sets per convolution window.
REQ-004 SHALL have parameter STRIDE, default 1, meaning sets released per completed window.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous and active-low.
REQ-007 SHALL have port start, input, 1, begin layer.
REQ-008 SHALL have port cfg_num_windows, input, 16, windows in layer, sampled on accepted start.
REQ-009 SHALL have port load_req, input, 1, upstream holds a batch of IN_NUM_OF_SET sets.
REQ-010 SHALL have port load_ack, output, 1, batch accepted this cycle.
REQ-011 SHALL have port buf_wen, output, 1, buffer write enable, identical to load_ack.
REQ-012 SHALL have port buf_full, input, 1, buffer full flag.
REQ-013 SHALL have port buf_valid, input, OUT_NUM_OF_SET, per-output-set valid from buffer.
REQ-014 SHALL have port buf_clr, output, 1, one-cycle buffer flush at layer end.
REQ-015 SHALL have port pe_start, output, 1, one-cycle pulse, PE array consumes buffer dout.
REQ-016 SHALL have port pe_busy, input, 1, PE array busy.
REQ-017 SHALL have port pe_done, input, 1, one-cycle pulse, window finished.
REQ-018 SHALL have port busy, output, 1, state not IDLE.
REQ-019 SHALL have port done, output, 1, one-cycle layer-complete pulse.
REQ-020 SHALL have port window_cnt, output, 16, windows completed this layer.
REQ-021 SHALL have port occupancy, output, $clog2(BUFFER_SIZE)+1, sets held in buffer.

Function
REQ-022 SHALL fail elaboration unless BUFFER_SIZE >= IN_NUM_OF_SET + OUT_NUM_OF_SET - 1 and STRIDE <= OUT_NUM_OF_SET, guaranteeing no load deadlock.
REQ-023 SHALL implement FSM IDLE, RUN, WAIT_PE, FIN; busy = (state != IDLE).
REQ-024 SHALL, in IDLE with start=1, latch N=cfg_num_windows, clear window_cnt, load rem_load=(N-1)*STRIDE+OUT_NUM_OF_SET (20-bit), and go RUN; if N=0, go FIN directly.
REQ-025 SHALL ignore start outside IDLE.
REQ-026 SHALL assert load_ack combinationally only when state in {RUN, WAIT_PE}, load_req=1, buf_full=0, rem_load>0, and occupancy+IN_NUM_OF_SET <= BUFFER_SIZE.
REQ-027 SHALL, on load_ack, add IN_NUM_OF_SET to occupancy and subtract IN_NUM_OF_SET from rem_load, saturating at 0.
REQ-028 SHALL, in RUN, when buf_valid all ones, occupancy >= OUT_NUM_OF_SET and pe_busy=0, go WAIT_PE; pe_start=1 exactly in the first cycle of WAIT_PE.
REQ-029 SHALL, in WAIT_PE on pe_done, subtract STRIDE from occupancy, increment window_cnt, and go FIN if window_cnt+1 == N, else RUN.
REQ-030 SHALL ignore pe_done outside WAIT_PE.
REQ-031 SHALL, on simultaneous load_ack and accepted pe_done, update occupancy by IN_NUM_OF_SET - STRIDE in one cycle.
REQ-032 SHALL, in FIN, assert done=1 and buf_clr=1 for exactly one cycle, zero occupancy and rem_load, hold window_cnt, and return to IDLE.
REQ-033 SHALL assert no load_ack in IDLE or FIN.

Reset
REQ-034 SHALL, on rst=0 at a rising edge, including mid-layer, force IDLE and zero occupancy, window_cnt, rem_load, pe_start, done and buf_clr; load_ack/buf_wen are 0 while in IDLE.

Verification
REQ-035 Reset: rst=0 for 2 cycles in WAIT_PE with occupancy=7 -> next cycle busy=0, occupancy=0, window_cnt=0, all pulses 0.
REQ-036 Single window: start with N=1, load_req=1 -> one load_ack, occupancy=4; buf_valid=3'b111 -> pe_start; pe_done -> occupancy=3, window_cnt=1, then done=1, buf_clr=1, occupancy=0.
REQ-037 Load limit: N=14, load_req held 1 -> exactly 4 load_acks total (rem_load 16), done after 14 pe_done pulses.
REQ-038 Capacity: occupancy=13, load_req=1 -> load_ack=0; after pe_done occupancy=12 -> load_ack=1, occupancy=16; then buf_full=1 blocks all loads.
REQ-039 Simultaneous: occupancy=10 in WAIT_PE, load_ack and pe_done same cycle -> occupancy=13.
REQ-040 Zero layer and ignored events: start with N=0 -> done pulse one cycle later, no pe_start; start while busy and pe_done in RUN -> no state or counter change.

Source files
------------

// File: rtl/buffer_scheduler.sv
// Sequences buffer loads and PE window launches for one convolution layer.
// Tracks buffer occupancy and stops loading once the layer's sets are in.
module buffer_scheduler #(
  parameter int BUFFER_SIZE    = 16,
  parameter int IN_NUM_OF_SET  = 4,
  parameter int OUT_NUM_OF_SET = 3,
  parameter int STRIDE         = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [15:0]                   cfg_num_windows,
  input  logic                          load_req,
  output logic                          load_ack,
  output logic                          buf_wen,
  input  logic                          buf_full,
  input  logic [OUT_NUM_OF_SET-1:0]     buf_valid,
  output logic                          buf_clr,
  output logic                          pe_start,
  input  logic                          pe_busy,
  input  logic                          pe_done,
  output logic                          busy,
  output logic                          done,
  output logic [15:0]                   window_cnt,
  output logic [$clog2(BUFFER_SIZE):0]  occupancy
);

  localparam int OW = $clog2(BUFFER_SIZE) + 1;

  if (BUFFER_SIZE < IN_NUM_OF_SET + OUT_NUM_OF_SET - 1 ||
      STRIDE > OUT_NUM_OF_SET) begin : g_bad_cfg
    $error("buffer_scheduler: configuration can deadlock loads");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT_PE,
    FIN
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [15:0]   n_reg;
  logic [19:0]   rem_load;
  logic [19:0]   rem_init;
  logic [19:0]   rem_sat;
  logic [OW-1:0] occ_n;
  logic          can_fit;
  logic          load_ok;
  logic          win_done;
  logic          launch;

  assign rem_init = 20'((32'(cfg_num_windows) - 32'd1) * 32'(STRIDE)
                        + 32'(OUT_NUM_OF_SET));
  assign rem_sat  = (rem_load > 20'(IN_NUM_OF_SET)) ?
                    rem_load - 20'(IN_NUM_OF_SET) : '0;
  assign can_fit  = (32'(occupancy) + 32'(IN_NUM_OF_SET))
                    <= 32'(BUFFER_SIZE);
  assign load_ok  = load_req & ~buf_full & (rem_load != '0) & can_fit;

  always_comb begin
    state_n  = state;
    load_ack = 1'b0;
    win_done = 1'b0;
    launch   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_n = (cfg_num_windows == 16'd0) ? FIN : RUN;
      end
      RUN: begin
        load_ack = load_ok;
        if (&buf_valid && !pe_busy &&
            32'(occupancy) >= 32'(OUT_NUM_OF_SET)) begin
          state_n = WAIT_PE;
          launch  = 1'b1;
        end
      end
      WAIT_PE: begin
        load_ack = load_ok;
        if (pe_done) begin
          win_done = 1'b1;
          state_n  = (window_cnt + 16'd1 == n_reg) ? FIN : RUN;
        end
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // A load and a window release in the same cycle net out in one update
  assign occ_n = occupancy
               + (load_ack ? OW'(IN_NUM_OF_SET) : '0)
               - (win_done ? OW'(STRIDE) : '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      n_reg      <= '0;
      rem_load   <= '0;
      occupancy  <= '0;
      window_cnt <= '0;
      pe_start   <= 1'b0;
    end else begin
      state    <= state_n;
      pe_start <= launch;
      if (state == IDLE) begin
        if (start) begin
          n_reg      <= cfg_num_windows;
          window_cnt <= '0;
          rem_load   <= (cfg_num_windows == 16'd0) ? '0 : rem_init;
        end
      end else if (state == FIN) begin
        occupancy <= '0;
        rem_load  <= '0;
      end else begin
        occupancy <= occ_n;
        if (load_ack)
          rem_load <= rem_sat;
        if (win_done)
          window_cnt <= window_cnt + 16'd1;
      end
    end
  end

  assign buf_wen = load_ack;
  assign busy    = (state != IDLE);
  assign done    = (state == FIN);
  assign buf_clr = (state == FIN);

endmodule

// File: tb/tb_buffer_scheduler.sv
// Directed scenarios plus randomized traffic against a layer-level model
// of the buffer scheduler.
module tb_buffer_scheduler;

  localparam int BS  = 16;
  localparam int IN  = 4;
  localparam int OUT = 3;
  localparam int S   = 1;
  localparam int OW  = $clog2(BS) + 1;

  logic           clk;
  logic           rst;
  logic           start;
  logic [15:0]    cfg;
  logic           load_req;
  logic           load_ack;
  logic           buf_wen;
  logic           buf_full;
  logic [OUT-1:0] buf_valid;
  logic           buf_clr;
  logic           pe_start;
  logic           pe_busy;
  logic           pe_done;
  logic           busy;
  logic           done;
  logic [15:0]    window_cnt;
  logic [OW-1:0]  occupancy;

  int checks = 0;
  int errors = 0;

  buffer_scheduler #(
    .BUFFER_SIZE(BS),
    .IN_NUM_OF_SET(IN),
    .OUT_NUM_OF_SET(OUT),
    .STRIDE(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .cfg_num_windows(cfg),
    .load_req(load_req),
    .load_ack(load_ack),
    .buf_wen(buf_wen),
    .buf_full(buf_full),
    .buf_valid(buf_valid),
    .buf_clr(buf_clr),
    .pe_start(pe_start),
    .pe_busy(pe_busy),
    .pe_done(pe_done),
    .busy(busy),
    .done(done),
    .window_cnt(window_cnt),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Layer-level reference: sets loaded vs. sets the layer needs,
  // windows finished vs. windows requested.
  bit m_active, m_fin, m_inwin, m_launch;
  int m_n, m_wins, m_loaded, m_need, m_occ;

  function automatic bit m_ack();
    return m_active && load_req && !buf_full &&
           (m_loaded < m_need) && (m_occ + IN <= BS);
  endfunction

  function automatic void model_step();
    bit ack;
    bit launch_n;
    int occ_before;
    ack = m_ack();
    launch_n = 1'b0;
    if (!rst) begin
      m_active = 0; m_fin = 0; m_inwin = 0;
      m_occ = 0; m_wins = 0; m_loaded = 0; m_need = 0; m_n = 0;
    end else if (m_fin) begin
      m_fin = 0;
      m_occ = 0;
    end else if (!m_active) begin
      if (start) begin
        m_n = int'(cfg);
        m_wins = 0;
        m_loaded = 0;
        m_need = (m_n - 1) * S + OUT;
        m_inwin = 0;
        if (m_n == 0) m_fin = 1;
        else m_active = 1;
      end
    end else begin
      occ_before = m_occ;
      if (ack) begin
        m_occ += IN;
        m_loaded += IN;
      end
      if (m_inwin) begin
        if (pe_done) begin
          m_occ -= S;
          m_wins++;
          m_inwin = 0;
          if (m_wins == m_n) begin
            m_active = 0;
            m_fin = 1;
          end
        end
      end else if (&buf_valid && !pe_busy && occ_before >= OUT) begin
        m_inwin = 1;
        launch_n = 1;
      end
    end
    m_launch = launch_n;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_loads(input int k, output bit ok);
    int cnt = 0;
    load_req = 1'b1;
    for (int i = 0; i < 40 && cnt < k; i++) begin
      #1;
      if (load_ack === 1'b1) cnt++;
      tick();
    end
    load_req = 1'b0;
    ok = (cnt == k);
  endtask

  task automatic do_window(output bit ok);
    ok = 0;
    buf_valid = '1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (pe_start === 1'b1) ok = 1;
      tick();
    end
    buf_valid = '0;
    if (ok) begin
      pe_done = 1'b1;
      tick();
      pe_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    load_req = 1'b1;
    tick();
    tick();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
    checks++; if (window_cnt !== 16'd0) begin errors++; $display("FAIL rst_wcnt got=%0d exp=0", window_cnt); end
    checks++; if (load_ack !== 1'b0 || buf_wen !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b%b exp=00", load_ack, buf_wen); end
    checks++; if ({done, buf_clr, pe_start} !== 3'b000) begin errors++; $display("FAIL rst_pulses got=%b exp=000", {done, buf_clr, pe_start}); end
    load_req = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_window();
    start = 1'b1; cfg = 16'd1;
    tick();
    start = 1'b0;
    load_req = 1'b1;
    #1;
    checks++; if (load_ack !== 1'b1 || buf_wen !== 1'b1) begin errors++; $display("FAIL sw_ack got=%b%b exp=11", load_ack, buf_wen); end
    tick();
    #1;
    checks++; if (occupancy !== 5'd4) begin errors++; $display("FAIL sw_occ4 got=%0d exp=4", occupancy); end
    checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL sw_noload got=%b exp=0", load_ack); end
    load_req = 1'b0;
    buf_valid = '1;
    tick();
    #1;
    checks++; if (pe_start !== 1'b1) begin errors++; $display("FAIL sw_pestart got=%b exp=1", pe_start); end
    buf_valid = '0;
    tick();
    #1;
    checks++; if (pe_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL sw_pulse1 got=%b%b exp=01", pe_start, busy); end
    pe_done = 1'b1;
    tick();
    pe_done = 1'b0;
    #1;
    checks++; if (occupancy !== 5'd3) begin errors++; $display("FAIL sw_occ3 got=%0d exp=3", occupancy); end
    checks++; if (window_cnt !== 16'd1) begin errors++; $display("FAIL sw_wcnt got=%0d exp=1", window_cnt); end
    checks++; if (done !== 1'b1 || buf_clr !== 1'b1) begin errors++; $display("FAIL sw_done got=%b%b exp=11", done, buf_clr); end
    tick();
    #1;
    checks++; if (done !== 1'b0 || buf_clr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL sw_idle got=%b%b%b exp=000", done, buf_clr, busy); end
    checks++; if (occupancy !== '0 || window_cnt !== 16'd1) begin errors++; $display("FAIL sw_after got=%0d/%0d exp=0/1", occupancy, window_cnt); end
  endtask

  task automatic test_load_limit();
    int acks = 0;
    int starts = 0;
    bit pend = 0;
    bit seen = 0;
    start = 1'b1; cfg = 16'd14;
    tick();
    start = 1'b0;
    load_req = 1'b1;
    buf_valid = '1;
    for (int i = 0; i < 300 && !seen; i++) begin
      pe_done = pend;
      pend = 0;
      #1;
      if (load_ack === 1'b1) acks++;
      if (pe_start === 1'b1) begin pend = 1; starts++; end
      if (done === 1'b1) seen = 1;
      else tick();
    end
    pe_done = 1'b0;
    load_req = 1'b0;
    buf_valid = '0;
    checks++; if (!seen) begin errors++; $display("FAIL ll_timeout got=no_done exp=done"); end
    checks++; if (acks != 4) begin errors++; $display("FAIL ll_acks got=%0d exp=4", acks); end
    checks++; if (starts != 14) begin errors++; $display("FAIL ll_starts got=%0d exp=14", starts); end
    checks++; if (window_cnt !== 16'd14) begin errors++; $display("FAIL ll_wcnt got=%0d exp=14", window_cnt); end
    tick();
  endtask

  task automatic test_capacity();
    bit ok;
    start = 1'b1; cfg = 16'd20;
    tick();
    start = 1'b0;
    do_loads(4, ok);
    #1;
    checks++; if (!ok || occupancy !== 5'd16) begin errors++; $display("FAIL cap_fill got=%0d exp=16", occupancy); end
    for (int k = 0; k < 3; k++) begin
      do_window(ok);
      checks++; if (!ok) begin errors++; $display("FAIL cap_win got=timeout exp=pe_start"); end
    end
    load_req = 1'b1;
    #1;
    checks++; if (occupancy !== 5'd13) begin errors++; $display("FAIL cap_occ13 got=%0d exp=13", occupancy); end
    checks++; if (load_ack !== 1'b0) begin errors++; $display("FAIL cap_block got=%b exp=0", load_ack); end
    do_window(ok);
    #1;
    checks++; if (!ok || occupancy !== 5'd12) begin errors++; $display("FAIL cap_occ12 got=%0d exp=12", occupancy); end
    checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL cap_fit got=%b exp=1", load_ack); end
    tick();
    load_req = 1'b0;
    #1;
    checks++; if (occupancy !== 5'd16) begin errors++; $display("FAIL cap_occ16 got=%0d exp=16", occupancy); end
    for (int k = 0; k < 4; k++) do_window(ok);
    load_req = 1'b1;
    buf_full = 1'b1;
    #1;
    checks++; if (load_ack !== 1'b0 || occupancy !== 5'd12) begin errors++; $display("FAIL cap_full got=%b/%0d exp=0/12", load_ack, occupancy); end
    tick();
    #1;
    checks++; if (load_ack !== 1'b0 || occupancy !== 5'd12) begin errors++; $display("FAIL cap_full2 got=%b/%0d exp=0/12", load_ack, occupancy); end
    buf_full = 1'b0;
    #1;
    checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL cap_unfull got=%b exp=1", load_ack); end
    load_req = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_simultaneous();
    bit ok;
    bit seen = 0;
    start = 1'b1; cfg = 16'd20;
    tick();
    start = 1'b0;
    do_loads(3, ok);
    do_window(ok);
    do_window(ok);
    buf_valid = '1;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (pe_start === 1'b1) seen = 1;
      tick();
    end
    buf_valid = '0;
    #1;
    checks++; if (!seen || occupancy !== 5'd10) begin errors++; $display("FAIL sim_occ10 got=%0d exp=10", occupancy); end
    pe_done = 1'b1;
    load_req = 1'b1;
    #1;
    checks++; if (load_ack !== 1'b1) begin errors++; $display("FAIL sim_ack got=%b exp=1", load_ack); end
    tick();
    pe_done = 1'b0;
    load_req = 1'b0;
    #1;
    checks++; if (occupancy !== 5'd13) begin errors++; $display("FAIL sim_occ13 got=%0d exp=13", occupancy); end
    checks++; if (window_cnt !== 16'd3) begin errors++; $display("FAIL sim_wcnt got=%0d exp=3", window_cnt); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen = 0;
    start = 1'b1; cfg = 16'd5;
    tick();
    start = 1'b0;
    do_loads(2, ok);
    do_window(ok);
    buf_valid = '1;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (pe_start === 1'b1) seen = 1;
      tick();
    end
    buf_valid = '0;
    #1;
    checks++; if (!seen || occupancy !== 5'd7 || window_cnt !== 16'd1) begin errors++; $display("FAIL rm_pre got=%0d/%0d exp=7/1", occupancy, window_cnt); end
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    load_req = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || occupancy !== '0) begin errors++; $display("FAIL rm_state got=%b/%0d exp=0/0", busy, occupancy); end
    checks++; if (window_cnt !== 16'd0) begin errors++; $display("FAIL rm_wcnt got=%0d exp=0", window_cnt); end
    checks++; if ({pe_start, done, buf_clr, load_ack} !== 4'b0000) begin errors++; $display("FAIL rm_pulses got=%b exp=0000", {pe_start, done, buf_clr, load_ack}); end
    load_req = 1'b0;
    tick();
  endtask

  task automatic test_zero_and_ignored();
    bit ok;
    start = 1'b1; cfg = 16'd0;
    tick();
    start = 1'b0;
    #1;
    checks++; if (done !== 1'b1 || buf_clr !== 1'b1 || pe_start !== 1'b0) begin errors++; $display("FAIL zl_fin got=%b%b%b exp=110", done, buf_clr, pe_start); end
    tick();
    #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zl_idle got=%b%b exp=00", done, busy); end
    start = 1'b1; cfg = 16'd5;
    tick();
    cfg = 16'd1;
    pe_done = 1'b1;
    tick();
    start = 1'b0;
    pe_done = 1'b0;
    #1;
    checks++; if (busy !== 1'b1 || window_cnt !== 16'd0 || occupancy !== '0) begin errors++; $display("FAIL ig_run got=%b/%0d/%0d exp=1/0/0", busy, window_cnt, occupancy); end
    do_loads(1, ok);
    do_window(ok);
    #1;
    checks++; if (!ok || window_cnt !== 16'd1 || occupancy !== 5'd3) begin errors++; $display("FAIL ig_win got=%0d/%0d exp=1/3", window_cnt, occupancy); end
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ig_start got=%b%b exp=01", done, busy); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_random();
    int layers = 0;
    for (int c = 0; c < 4000; c++) begin
      rst       = ($urandom_range(0, 499) != 0);
      start     = ($urandom_range(0, 9) == 0);
      cfg       = 16'($urandom_range(0, 8));
      load_req  = ($urandom_range(0, 3) != 0);
      buf_full  = ($urandom_range(0, 7) == 0);
      buf_valid = ($urandom_range(0, 3) != 0) ? '1 : OUT'($urandom);
      pe_busy   = ($urandom_range(0, 4) == 0);
      pe_done   = ($urandom_range(0, 2) == 0);
      #1;
      checks++; if (load_ack !== m_ack()) begin errors++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", c, load_ack, m_ack()); end
      checks++; if (buf_wen !== m_ack()) begin errors++; $display("FAIL rnd_wen cyc=%0d got=%b exp=%b", c, buf_wen, m_ack()); end
      checks++; if (pe_start !== m_launch) begin errors++; $display("FAIL rnd_pestart cyc=%0d got=%b exp=%b", c, pe_start, m_launch); end
      checks++; if (done !== m_fin || buf_clr !== m_fin) begin errors++; $display("FAIL rnd_done cyc=%0d got=%b%b exp=%b", c, done, buf_clr, m_fin); end
      checks++; if (busy !== (m_active | m_fin)) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, busy, m_active | m_fin); end
      checks++; if (window_cnt !== 16'(m_wins)) begin errors++; $display("FAIL rnd_wcnt cyc=%0d got=%0d exp=%0d", c, window_cnt, m_wins); end
      checks++; if (occupancy !== OW'(m_occ)) begin errors++; $display("FAIL rnd_occ cyc=%0d got=%0d exp=%0d", c, occupancy, m_occ); end
      if (m_fin) layers++;
      tick();
    end
    rst = 1'b1; start = 1'b0; load_req = 1'b0; buf_full = 1'b0;
    buf_valid = '0; pe_busy = 1'b0; pe_done = 1'b0;
    checks++; if (layers < 5) begin errors++; $display("FAIL rnd_layers got=%0d exp=>=5", layers); end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; cfg = '0; load_req = 1'b0;
    buf_full = 1'b0; buf_valid = '0; pe_busy = 1'b0; pe_done = 1'b0;
    test_reset();
    test_single_window();
    test_load_limit();
    test_capacity();
    test_simultaneous();
    test_reset_mid();
    test_zero_and_ignored();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
